// File: rtl/dm_pkg.sv
// Shared encodings and the latched-access record for the data-memory access controller.
package dm_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } state_e;

  typedef struct packed {
    logic        wr;
    size_e       size;
    logic        sext;
    logic [1:0]  lane;
    logic        port;
    logic        err;
    logic [31:0] wdata;
  } acc_t;

  // Reserved size is never a legal access.
  function automatic logic misaligned(input size_e sz, input logic [1:0] a);
    case (sz)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return a[0];
      SZ_WORD: return |a;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dm_lane_unit.sv
// Byte-lane steering: load extraction with sign/zero extension, and sub-word store merge.
module dm_lane_unit
  import dm_pkg::*;
(
  input  size_e       size,
  input  logic        sext,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic [31:0] merged
);

  logic [3:0][7:0] wb;
  logic [3:0][7:0] mb;
  logic [7:0]      b;
  logic [15:0]     h;

  assign wb = word;

  always_comb begin
    b = wb[lane];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: ldata = {{24{sext & b[7]}}, b};
      SZ_HALF: ldata = {{16{sext & h[15]}}, h};
      default: ldata = word;
    endcase
  end

  // Little-endian: lane k is bits [8k+7:8k]; a half store feeds wdata bytes 0/1 into lanes 2k/2k+1.
  for (genvar k = 0; k < 4; k++) begin : g_lane
    localparam logic [1:0] K = 2'(k);
    logic hit;
    assign hit   = (size == SZ_BYTE && lane == K) || (size == SZ_HALF && lane[1] == K[1]);
    assign mb[k] = !hit ? wb[k] : (size == SZ_BYTE ? wdata[7:0] : wdata[8*(k%2) +: 8]);
  end

  assign merged = mb;

endmodule

// File: rtl/dm_arb_ctrl.sv
// Two-port arbiter and access sequencer in front of a word-wide data memory:
// sub-word loads are extracted, sub-word stores are done as read-modify-write.
module dm_arb_ctrl
  import dm_pkg::*;
#(
  parameter int AW    = 10,
  parameter bit RR_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_req,
  input  logic          p0_wr,
  input  logic [1:0]    p0_size,
  input  logic          p0_sext,
  input  logic [AW-1:0] p0_addr,
  input  logic [31:0]   p0_wdata,
  output logic          p0_gnt,
  output logic          p0_done,
  output logic          p0_err,
  input  logic          p1_req,
  input  logic          p1_wr,
  input  logic [1:0]    p1_size,
  input  logic          p1_sext,
  input  logic [AW-1:0] p1_addr,
  input  logic [31:0]   p1_wdata,
  output logic          p1_gnt,
  output logic          p1_done,
  output logic          p1_err,
  output logic [31:0]   rdata,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_din,
  output logic          mem_we,
  input  logic [31:0]   mem_dout
);

  state_e        state, state_nxt;
  acc_t          acc, acc_nxt;
  logic          rr_last, win, any_req, grant, sub_st;
  logic [AW-1:0] addr_sel;
  logic [31:0]   ldata, merged;

  assign any_req = p0_req | p1_req;
  assign grant   = rst_n & any_req & (state == IDLE);
  assign sub_st  = acc.wr & (acc.size != SZ_WORD);

  // rr_last records the port served last; under contention the other one wins.
  always_comb begin
    if (p0_req && p1_req) win = RR_EN ? ~rr_last : 1'b0;
    else                  win = p1_req;
  end

  always_comb begin
    addr_sel      = win ? p1_addr : p0_addr;
    acc_nxt.wr    = win ? p1_wr : p0_wr;
    acc_nxt.size  = size_e'(win ? p1_size : p0_size);
    acc_nxt.sext  = win ? p1_sext : p0_sext;
    acc_nxt.wdata = win ? p1_wdata : p0_wdata;
    acc_nxt.lane  = addr_sel[1:0];
    acc_nxt.port  = win;
    acc_nxt.err   = misaligned(acc_nxt.size, addr_sel[1:0]);
  end

  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    case (state)
      IDLE:   if (any_req) state_nxt = acc_nxt.err ? RESP : ACCESS;
      ACCESS: begin
        mem_we    = acc.wr & (acc.size == SZ_WORD);
        state_nxt = sub_st ? WRITE : RESP;
      end
      WRITE:  begin
        mem_we    = 1'b1;
        state_nxt = RESP;
      end
      default: state_nxt = IDLE;
    endcase
    p0_gnt = grant & ~win;
    p1_gnt = grant & win;
  end

  assign p0_done = (state == RESP) & ~acc.port;
  assign p1_done = (state == RESP) & acc.port;
  assign p0_err  = p0_done & acc.err;
  assign p1_err  = p1_done & acc.err;

  dm_lane_unit u_lane (
    .size   (acc.size),
    .sext   (acc.sext),
    .lane   (acc.lane),
    .word   (mem_dout),
    .wdata  (acc.wdata),
    .ldata  (ldata),
    .merged (merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_last  <= 1'b1;
      acc      <= '0;
      rdata    <= '0;
      mem_addr <= '0;
      mem_din  <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        acc      <= acc_nxt;
        rr_last  <= win;
        mem_addr <= {addr_sel[AW-1:2], 2'b00};
        mem_din  <= acc_nxt.wdata;
      end
      // mem_din already holds wdata for a word store; sub-word stores swap in the merged word for WRITE.
      if (state == ACCESS) begin
        if (!acc.wr)     rdata   <= ldata;
        else if (sub_st) mem_din <= merged;
      end
    end
  end

endmodule

// File: doc/dm_arb_ctrl.md
Name: dm_arb_ctrl

Overview:
- Access controller placed in front of the 1 KB byte-addressed data memory of the multi-cycle CPU.
- Arbitrates between two requesters: port 0 is the CPU load/store unit, port 1 is the debug/loader port.
- Converts byte, halfword and word loads/stores into word-aligned memory accesses; sub-word stores are done as read-modify-write because the memory writes whole words only.
- Performs sign/zero extension on loads and flags misaligned accesses.

Parameters:
AW, 10, byte-address width, matches the memory address bus
RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority with port 0 winning

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
pN_req  in  1  request from port N (N=0,1); held with its payload until pN_gnt
pN_wr  in  1  1 = store, 0 = load
pN_size  in  2  00 byte, 01 half, 10 word; 11 reserved, treated as misaligned
pN_sext  in  1  load sign-extend enable, ignored on stores
pN_addr  in  AW  byte address
pN_wdata  in  32  store data; the payload sits in the low bits for byte/half
pN_gnt  out  1  one-cycle pulse, payload latched this cycle
pN_done  out  1  one-cycle pulse, access complete
pN_err  out  1  valid with pN_done; misaligned, no memory side effect
rdata  out  32  load result, valid with pN_done, held until next done
mem_addr  out  AW  to memory; always word aligned, low 2 bits = 0
mem_din  out  32  to memory write data
mem_we  out  1  to memory write enable
mem_dout  in  32  from memory; combinational read of mem_addr

Behaviour:
- Reset, asynchronous on rst_n low:
  - state = IDLE; rr pointer favours port 0.
  - All gnt/done/err = 0; rdata = 0; mem_addr = 0; mem_din = 0.
  - mem_we = 0 immediately, because it is decoded from state.
  - A reset during an access abandons it: no write happens and no done is issued.
- State machine: IDLE -> ACCESS -> (WRITE) -> RESP -> IDLE.
- IDLE:
  - If any req is high, pick the winner, pulse its gnt, and latch wr, size, sext, addr, wdata and the port id.
  - If both are requesting: with RR_EN=1 the port not served last wins; with RR_EN=0 port 0 wins. The rr pointer updates on each grant.
  - Alignment check at latch: half needs addr[0]=0; word needs addr[1:0]=0; size 11 is always bad. A bad access goes directly to RESP with err=1 and no memory access.
- ACCESS (mem_addr = {addr[AW-1:2],2'b00}):
  - Load: select lane addr[1:0] (byte) or addr[1] (half) from mem_dout, extend per sext, register into rdata, go RESP.
  - Word store: mem_we=1 and mem_din=wdata this cycle, go RESP.
  - Byte/half store: capture mem_dout into a merge buffer, replace the addressed lane(s) with wdata[7:0] or wdata[15:0], go WRITE.
- WRITE: mem_we=1 with the merged word on the same mem_addr; go RESP.
- RESP: pulse done (and err if set) on the latched port; go IDLE. A new grant is possible only on the following cycle.
- Latency from the gnt cycle to the done cycle:
  - load or word store: 2 cycles
  - sub-word store: 3 cycles
  - misaligned: 1 cycle
- Throughput: at most one access in flight.
- The requester may drop req before it is granted; the request is then simply lost.
- req must deassert or present a new payload after gnt; a req still high in IDLE after RESP is treated as a new request.
- The memory is little-endian: byte lane k occupies mem word bits [8k+7:8k].
- mem_we is never high outside ACCESS (word store) or WRITE.

Decomposition:
- Shared package dm_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD
  - state encoding IDLE, ACCESS, WRITE, RESP
- One sub-module, dm_lane_unit (combinational): load extraction/extension and store lane merge, given size, sext and addr[1:0].

Test Plan:
- Memory word 0x40 = 0x8899AABB; p0 byte load at addr 0x42 with sext=1 -> rdata=0xFFFFFF99 and p0_done 2 cycles after gnt; with sext=0 -> 0x00000099.
- Word 0x40 = 0x8899AABB; p0 half store at addr 0x42 with wdata=0x1234 -> exactly one mem_we cycle (WRITE state) and word reads back 0x1234AABB; done 3 cycles after gnt.
- p0 and p1 both request continuously with RR_EN=1 -> grants alternate 0,1,0,1; with RR_EN=0 -> port 0 is always granted.
- p1 word load at addr 0x13 -> p1_done with p1_err=1 one cycle after gnt, mem_we never asserted, memory unchanged.
- rst_n asserted low in the WRITE cycle of a byte store to 0x20 (old value 0x11223344) -> mem_we drops immediately, word stays 0x11223344, no done issued, and after release p0 wins the first contention.
